// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: in-order circular buffer with
// halt latch, synchronous flush, and a PC+2 companion on the head.
module fetch_decode_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fetch_valid,
  input  logic [15:0]                fetch_instr,
  input  logic [15:0]                fetch_pc,
  output logic                       fetch_ready,
  output logic                       dec_valid,
  output logic [15:0]                dec_instr,
  output logic [15:0]                dec_pc,
  output logic [15:0]                dec_pc_plus2,
  input  logic                       dec_ready,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [15:0] NOP  = 16'h0800;
  localparam logic [15:0] HALT = 16'h0000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;

  typedef enum logic {
    OPEN,
    CLOSED
  } state_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  state_t        state;
  state_t        state_n;

  logic full;
  logic empty;
  logic enq;
  logic deq;
  logic halt_in;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign halted  = (state == CLOSED);
  assign halt_in = (fetch_instr == HALT);

  assign fetch_ready = !full && !halted;
  assign dec_valid   = !empty;

  // Flush discards any handshake in the same cycle.
  assign enq = fetch_valid && fetch_ready && !flush;
  assign deq = dec_valid && dec_ready && !flush;

  assign count = cnt;

  always_comb begin
    state_n = state;
    unique case (state)
      OPEN:    if (enq && halt_in) state_n = CLOSED;
      CLOSED:  state_n = CLOSED;
      default: state_n = OPEN;
    endcase
    if (flush) state_n = OPEN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= OPEN;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case ({enq, deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{instr: fetch_instr, pc: fetch_pc};
  end

  entry_t head;
  assign head = mem[rd_ptr];

  always_comb begin
    dec_instr = NOP;
    dec_pc    = 16'h0000;
    if (dec_valid) begin
      dec_instr = head.instr;
      dec_pc    = head.pc;
    end
  end

  assign dec_pc_plus2 = dec_pc + 16'd2;

endmodule
